// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants one of NUM_CH requester channels access to a single
// memory port for a whole burst, walking a per-channel byte-address pointer.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start_layer       - reload pointers from ch_base_addr, abort active burst
//   ch_base_addr      - per-channel layer base address (packed NUM_CH*ADDR_W)
//   ch_is_write       - per-channel direction, 1 = write
//   ch_req            - per-channel burst request
//   ch_burst_len      - per-channel beat count, sampled at grant
//   ch_wdata          - per-channel write beat
//   ch_grant          - one-hot grant, held for the burst
//   ch_wack/ch_rvalid - per-beat write accept / read valid to the owner
//   ch_rdata          - shared read data
//   mem_*             - memory-side request/response
//   busy              - burst in progress
module mem_port_arbiter #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 8,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_layer,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_base_addr,
    input  logic [NUM_CH-1:0]          ch_is_write,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH*LEN_W-1:0]    ch_burst_len,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_grant,
    output logic [NUM_CH-1:0]          ch_wack,
    output logic [NUM_CH-1:0]          ch_rvalid,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_write_data,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic                       mem_valid,
    input  logic [DATA_W-1:0]          mem_read_data,
    output logic                       busy
);

    localparam int unsigned       IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [IDX_W-1:0]  LAST_RST   = IDX_W'(NUM_CH - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr [NUM_CH];
    logic [IDX_W-1:0]    last_grant;
    logic [LEN_W-1:0]    remaining;

    logic [NUM_CH-1:0]   eligible;
    logic [LEN_W-1:0]    len_arr   [NUM_CH];
    logic [ADDR_W-1:0]   base_arr  [NUM_CH];
    logic [DATA_W-1:0]   wdata_arr [NUM_CH];

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [LEN_W-1:0]    win_len;
    int unsigned         cand;
    logic [IDX_W-1:0]    cand_idx;

    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;
    logic                beat;

    // Unpack per-channel buses; zero-length requests are never eligible.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign len_arr[i]   = ch_burst_len[i*LEN_W +: LEN_W];
        assign base_arr[i]  = ch_base_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = ch_wdata[i*DATA_W +: DATA_W];
        assign eligible[i]  = ch_req[i] & (len_arr[i] != '0);
    end

    // Winner search: upward from last_grant+1 (round-robin) or from 0 (fixed).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_len   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (RR_EN) begin
                cand = (32'(last_grant) + 32'(k) + 32'd1) % NUM_CH;
            end else begin
                cand = k;
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && eligible[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
                win_len   = len_arr[cand_idx];
            end
        end
    end

    // Granted-channel mux; grant is zero outside XFER so both buses idle at 0.
    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_grant[i]) begin
                addr_sel  = addr_sel  | ptr[i];
                wdata_sel = wdata_sel | wdata_arr[i];
            end
        end
    end

    assign busy           = (state == XFER);
    assign beat           = busy & mem_valid;
    assign mem_addr       = addr_sel;
    assign mem_write_data = wdata_sel;
    assign mem_read       = busy & |(ch_grant & ~ch_is_write);
    assign mem_write      = busy & |(ch_grant & ch_is_write);
    assign ch_wack        = {NUM_CH{beat}} & ch_grant & ch_is_write;
    assign ch_rvalid      = {NUM_CH{beat}} & ch_grant & ~ch_is_write;
    assign ch_rdata       = mem_read_data;

    // Burst FSM; start_layer overrides any grant or beat in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_grant   <= '0;
            last_grant <= LAST_RST;
            remaining  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ptr[i] <= '0;
            end
        end else if (start_layer) begin
            state     <= IDLE;
            ch_grant  <= '0;
            remaining <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ptr[i] <= base_arr[i];
            end
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state      <= XFER;
                        ch_grant   <= NUM_CH'(1) << win_idx;
                        remaining  <= win_len;
                        last_grant <= win_idx;
                    end
                end
                XFER: begin
                    if (mem_valid) begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (ch_grant[i]) begin
                                ptr[i] <= ptr[i] + BEAT_BYTES;
                            end
                        end
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state    <= IDLE;
                            ch_grant <= '0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    ch_grant <= '0;
                end
            endcase
        end
    end

endmodule
